// File: rtl/div_pkg.sv
// Shared types and constants for the div32 iterative divider.
// Holds FSM state encoding, default width and divide-by-zero quotient.
package div_pkg;

   localparam int DIV_WIDTH = 32;

   localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/div32_sub33.sv
// Trial subtractor for the divider: diff = a - b, borrow = a < b.
// Ports: a, b (W bits) in; diff (W bits), borrow out.
module sub33 #(
   parameter int W = 33
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         borrow
);

   assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/div32.sv
// Restoring divider, one quotient bit per cycle, signed or unsigned.
// Ports: clk, rst_n, start, is_signed, dividend, divisor in;
//        busy, done, quotient, remainder, div_by_zero out.
module div32
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam logic [4:0] LAST_ITER = 5'd31;

   div_state_e       state_q, state_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             negq_q, negq_d;
   logic             negr_q, negr_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   trial_a;
   logic [WIDTH:0]   trial_b;
   logic [WIDTH:0]   trial_diff;
   logic             trial_borrow;
   logic             unused_diff_msb;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] quo_nxt;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   // Partial remainder shifted left with the next dividend bit.
   assign trial_a = {rem_q, quo_q[WIDTH-1]};
   assign trial_b = {1'b0, dvs_q};

   sub33 #(
      .W (WIDTH + 1)
   ) u_sub (
      .a      (trial_a),
      .b      (trial_b),
      .diff   (trial_diff),
      .borrow (trial_borrow)
   );

   // With no borrow the difference is below the divisor, so its
   // top bit is always zero.
   assign unused_diff_msb = trial_diff[WIDTH];

   assign rem_nxt = trial_borrow ? trial_a[WIDTH-1:0]
                                 : trial_diff[WIDTH-1:0];
   assign quo_nxt = {quo_q[WIDTH-2:0], ~trial_borrow};

   assign a_neg = is_signed & dividend[WIDTH-1];
   assign b_neg = is_signed & divisor[WIDTH-1];
   assign a_mag = a_neg ? -dividend : dividend;
   assign b_mag = b_neg ? -divisor : divisor;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      negq_d      = negq_q;
      negr_d      = negr_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (divisor == '0) begin
                  state_d     = DONE;
                  quotient_d  = DIV0_QUOTIENT;
                  remainder_d = dividend;
                  dbz_d       = 1'b1;
               end else begin
                  state_d = RUN;
                  cnt_d   = '0;
                  rem_d   = '0;
                  quo_d   = a_mag;
                  dvs_d   = b_mag;
                  negq_d  = a_neg ^ b_neg;
                  negr_d  = a_neg;
               end
            end
         end
         RUN: begin
            rem_d = rem_nxt;
            quo_d = quo_nxt;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == LAST_ITER) begin
               state_d     = DONE;
               quotient_d  = negq_q ? -quo_nxt : quo_nxt;
               remainder_d = negr_q ? -rem_nxt : rem_nxt;
               dbz_d       = 1'b0;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         negq_q      <= 1'b0;
         negr_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         negq_q      <= negq_d;
         negr_q      <= negr_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32.sv
// Directed scoreboard bench for div32.
// Expected results come from a behavioural divide model.
module tb_div32;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        is_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int checks;
   int errors;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      int          lat;
   } exp_t;

   exp_t sb[$];

   div32 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(input logic sgn,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
      exp_t e;
      int   sa;
      int   sbv;
      sa  = $signed(a);
      sbv = $signed(b);
      e.dbz = 1'b0;
      e.lat = 33;
      if (b == 32'd0) begin
         e.q   = 32'hFFFF_FFFF;
         e.r   = a;
         e.dbz = 1'b1;
         e.lat = 1;
      end else if (!sgn) begin
         e.q = a / b;
         e.r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.q = 32'h8000_0000;
         e.r = 32'd0;
      end else begin
         e.q = 32'(sa / sbv);
         e.r = 32'(sa % sbv);
      end
      return e;
   endfunction

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called right after a falling edge; returns on a falling edge.
   task automatic run_op(input logic sgn,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input string tag,
                         input bit disturb);
      exp_t e;
      int   n;
      bit   seen;
      sb.push_back(model(sgn, a, b));
      is_signed = sgn;
      dividend  = a;
      divisor   = b;
      start     = 1'b1;
      @(posedge clk);
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (n == 1) chk({tag, "_busy"}, 32'(busy), 32'd1);
         if (done) seen = 1'b1;
         if (disturb && n == 9) begin
            start     = 1'b1;
            is_signed = 1'b1;
            dividend  = 32'd5000;
            divisor   = 32'd11;
         end else begin
            start = 1'b0;
         end
      end
      e = sb.pop_front();
      chk({tag, "_lat"}, 32'(n), 32'(e.lat));
      chk({tag, "_q"}, quotient, e.q);
      chk({tag, "_r"}, remainder, e.r);
      chk({tag, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(done), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
      chk({tag, "_hold"}, quotient, e.q);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      is_signed = 1'b0;
      dividend  = 32'd0;
      divisor   = 32'd0;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_q", quotient, 32'd0);
      chk("rst_r", remainder, 32'd0);
      chk("rst_dbz", 32'(div_by_zero), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_op(1'b0, 32'd100, 32'd7, "u100_7", 1'b0);
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2, "sm7_2", 1'b0);
      run_op(1'b0, 32'd5, 32'd0, "u5_0", 1'b0);
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "s_ovf", 1'b0);
      run_op(1'b0, 32'd100, 32'd7, "ign_start", 1'b1);
      run_op(1'b1, 32'hFFFF_FFF9, 32'd0, "s_div0", 1'b0);
      run_op(1'b1, 32'd7, 32'hFFFF_FFFE, "s7_m2", 1'b0);
      run_op(1'b0, 32'hFFFF_FFFF, 32'd1, "umax_1", 1'b0);
      run_op(1'b0, 32'hDEAD_BEEF, 32'h0001_2345, "ubig", 1'b0);

      is_signed = 1'b0;
      dividend  = 32'd1000;
      divisor   = 32'd3;
      start     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_q", quotient, 32'd0);
      chk("abort_r", remainder, 32'd0);
      chk("abort_dbz", 32'(div_by_zero), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_nodone", 32'(done), 32'd0);
      end
      rst_n = 1'b1;
      run_op(1'b0, 32'd9, 32'd3, "u9_3", 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
